// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM access scheduler: FSM encoding,
// default slot/refresh timing and client port indices.
package sdram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_REFRESH = 2'd2
   } arb_state_t;

   localparam int SLOT_LEN_DEFAULT         = 8;
   localparam int REFRESH_INTERVAL_DEFAULT = 480;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 8;

   localparam logic PORT_P0 = 1'b0;
   localparam logic PORT_P1 = 1'b1;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh down-counter with a single sticky pending flag.
// A tick landing in the same clock as a clear keeps the flag set, so no
// refresh request is ever lost; ticks while already pending do not queue up.
module sdram_refresh_timer
   import sdram_pkg::*;
#(
   parameter int INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic pending
);

   localparam int CNT_W = $clog2(INTERVAL);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(INTERVAL - 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             pending_q, pending_d;
   logic             tick;

   // Count down, reload at zero, and raise pending on the zero tick.
   always_comb begin
      tick      = (count_q == '0);
      count_d   = tick ? RELOAD : (count_q - CNT_W'(1));
      pending_d = tick | (pending_q & ~clear);
   end

   // Counter and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= RELOAD;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/sdram_arb.sv
// Two-port access scheduler in front of the single-slot SDRAM controller.
// Serves byte requests from p0 (CPU) and p1 (DMA/REU) in fixed slots and
// slips in an auto-refresh slot whenever the refresh timer asks for one.
// Build option: define SDRAM_ARB_RR_EN for a round-robin tie-break
// (the port not granted last wins a tie); otherwise p0 always wins a tie.
module sdram_arb
   import sdram_pkg::*;
#(
   parameter int SLOT_LEN         = SLOT_LEN_DEFAULT,
   parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_din,
   output logic [DATA_W-1:0] p0_dout,
   output logic              p0_ack,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_din,
   output logic [DATA_W-1:0] p1_dout,
   output logic              p1_ack,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              mem_refresh,
   output logic              busy
);

   localparam int CNT_W = $clog2(SLOT_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_LEN - 1);
   localparam logic [CNT_W-1:0] STROBE_END = CNT_W'(2);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              grant_q, grant_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic [DATA_W-1:0] p0_dout_q, p0_dout_d;
   logic [DATA_W-1:0] p1_dout_q, p1_dout_d;
   logic              p0_ack_q, p0_ack_d;
   logic              p1_ack_q, p1_ack_d;

   logic              refresh_pending;
   logic              refresh_clear;
   logic              slot_end;
   logic              req0_ok, req1_ok;
   logic              pick;

   sdram_refresh_timer #(
      .INTERVAL (REFRESH_INTERVAL)
   ) u_refresh_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (refresh_clear),
      .pending (refresh_pending)
   );

   // Slot sequencing, arbitration and completion. A new slot may start in
   // the last cycle of the previous one, so a client that is finishing now
   // (or whose ack is still visible) is ignored until it has seen its ack.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      grant_d       = grant_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_din_d     = mem_din_q;
      p0_dout_d     = p0_dout_q;
      p1_dout_d     = p1_dout_q;
      p0_ack_d      = 1'b0;
      p1_ack_d      = 1'b0;
      refresh_clear = 1'b0;
      pick          = PORT_P0;

      slot_end = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
      req0_ok  = p0_req && !p0_ack_q &&
                 !(slot_end && (state_q == ST_ACCESS) && (grant_q == PORT_P0));
      req1_ok  = p1_req && !p1_ack_q &&
                 !(slot_end && (state_q == ST_ACCESS) && (grant_q == PORT_P1));

`ifdef SDRAM_ARB_RR_EN
      if (req0_ok && req1_ok) begin
         pick = (grant_q == PORT_P0) ? PORT_P1 : PORT_P0;
      end else begin
         pick = req1_ok ? PORT_P1 : PORT_P0;
      end
`else
      pick = req0_ok ? PORT_P0 : PORT_P1;
`endif

      if ((state_q != ST_IDLE) && !slot_end) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (slot_end && (state_q == ST_ACCESS)) begin
         if (grant_q == PORT_P0) begin
            p0_ack_d = 1'b1;
            if (!mem_we_q) begin
               p0_dout_d = mem_dout;
            end
         end else begin
            p1_ack_d = 1'b1;
            if (!mem_we_q) begin
               p1_dout_d = mem_dout;
            end
         end
      end

      if ((state_q == ST_IDLE) || slot_end) begin
         cnt_d = '0;
         if (refresh_pending) begin
            state_d       = ST_REFRESH;
            refresh_clear = 1'b1;
         end else if (req0_ok || req1_ok) begin
            state_d    = ST_ACCESS;
            grant_d    = pick;
            mem_we_d   = (pick == PORT_P1) ? p1_we   : p0_we;
            mem_addr_d = (pick == PORT_P1) ? p1_addr : p0_addr;
            mem_din_d  = (pick == PORT_P1) ? p1_din  : p0_din;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // State and output registers; the last grant starts as p1 so p0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         grant_q    <= PORT_P1;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         p0_dout_q  <= '0;
         p1_dout_q  <= '0;
         p0_ack_q   <= 1'b0;
         p1_ack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         grant_q    <= grant_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         p0_dout_q  <= p0_dout_d;
         p1_dout_q  <= p1_dout_d;
         p0_ack_q   <= p0_ack_d;
         p1_ack_q   <= p1_ack_d;
      end
   end

   assign mem_ce      = (state_q == ST_ACCESS)  && (cnt_q < STROBE_END);
   assign mem_refresh = (state_q == ST_REFRESH) && (cnt_q < STROBE_END);
   assign busy        = (state_q != ST_IDLE);
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_din     = mem_din_q;
   assign p0_dout     = p0_dout_q;
   assign p1_dout     = p1_dout_q;
   assign p0_ack      = p0_ack_q;
   assign p1_ack      = p1_ack_q;

endmodule
